// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Hazard and sequencing controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
//  - detects RAW hazards between the ID instruction and EXE/MEM producers
//  - squashes wrong-path instructions on a taken branch resolved in EXE
//  - freezes the whole pipeline for a fixed-latency data-memory access
//  - keeps saturating stall / flush statistics
//
// Parameters
//   MEM_WAIT  total freeze cycles per memory access (1..15)
//   FWD_EN    1: forwarding present, only load-use is a hazard
//             0: any RAW against EXE/MEM is a hazard
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   id_src1/id_src2, id_use_src*   source registers of the ID instruction
//   exe_dest, exe_wb_en, exe_mem_r_en   EXE producer info
//   mem_dest, mem_wb_en            MEM producer info
//   mem_req                        MEM instruction accesses data memory
//   exe_br_taken                   taken branch resolved in EXE
//   freeze_pc, freeze_ifid         hold PC / IF-ID register
//   flush_ifid, flush_idex         bubble into IF-ID / ID-EX register
//   freeze_all                     hold every pipeline register
//   mem_ready                      one-cycle completion pulse
//   hazard                         raw hazard indication (debug)
//   stall_cycles, flush_count      saturating statistics

module pipeline_ctrl #(
    parameter int unsigned MEM_WAIT = 4,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_use_src1,
    input  logic        id_use_src2,
    input  logic [3:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic [3:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic        mem_req,
    input  logic        exe_br_taken,
    output logic        freeze_pc,
    output logic        freeze_ifid,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        freeze_all,
    output logic        mem_ready,
    output logic        hazard,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // WAIT is entered after the first freeze cycle and DONE consumes no
    // freeze cycle, so the counter starts at MEM_WAIT-2.
    localparam logic [3:0] CNT_LOAD = (MEM_WAIT >= 2) ? 4'(MEM_WAIT - 2) : 4'd0;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    logic w_match1;
    logic w_match2;
    logic w_hazard;
    logic w_freeze;
    logic w_branch;
    logic w_stall;

    // Producer match for each ID source operand.
    generate
        if (FWD_EN) begin : g_fwd
            // Only a load in EXE cannot be forwarded in time.
            assign w_match1 = exe_wb_en & exe_mem_r_en & (id_src1 == exe_dest);
            assign w_match2 = exe_wb_en & exe_mem_r_en & (id_src2 == exe_dest);
        end else begin : g_nofwd
            assign w_match1 = (exe_wb_en & (id_src1 == exe_dest)) |
                              (mem_wb_en & (id_src1 == mem_dest));
            assign w_match2 = (exe_wb_en & (id_src2 == exe_dest)) |
                              (mem_wb_en & (id_src2 == mem_dest));
        end
    endgenerate

    assign w_hazard = (id_use_src1 & w_match1) | (id_use_src2 & w_match2);

    // Priority: memory freeze > taken branch > hazard stall. Every output is
    // gated by rst so nothing leaks out while reset is held.
    assign w_freeze = ~rst & (((r_state == ST_RUN) & mem_req) | (r_state == ST_WAIT));
    assign w_branch = ~rst & ~w_freeze & exe_br_taken;
    assign w_stall  = ~rst & ~w_freeze & ~exe_br_taken & w_hazard;

    assign freeze_all   = w_freeze;
    assign freeze_pc    = w_freeze | w_stall;
    assign freeze_ifid  = w_freeze | w_stall;
    assign flush_ifid   = w_branch;
    assign flush_idex   = w_branch | w_stall;
    assign mem_ready    = ~rst & (r_state == ST_DONE);
    assign hazard       = ~rst & w_hazard;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

    // Wait-state FSM and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_cnt          <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_req) begin
                        if (MEM_WAIT == 1) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // Same instruction still sits in MEM: mem_req is ignored.
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_branch && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Two instances share the stimulus:
//   A: MEM_WAIT=4, FWD_EN=1    B: MEM_WAIT=1, FWD_EN=0
// Control vector order: {freeze_pc, freeze_ifid, flush_ifid, flush_idex,
//                        freeze_all, mem_ready, hazard}
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_use_src1, id_use_src2, exe_wb_en, exe_mem_r_en;
    logic       mem_wb_en, mem_req, exe_br_taken;

    logic        a_fpc, a_fifid, a_flifid, a_flidex, a_fall, a_rdy, a_haz;
    logic [15:0] a_stall, a_flush;
    logic        b_fpc, b_fifid, b_flifid, b_flidex, b_fall, b_rdy, b_haz;
    logic [15:0] b_stall, b_flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_WAIT(4), .FWD_EN(1'b1)) u_a (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .exe_br_taken(exe_br_taken),
        .freeze_pc(a_fpc), .freeze_ifid(a_fifid), .flush_ifid(a_flifid),
        .flush_idex(a_flidex), .freeze_all(a_fall), .mem_ready(a_rdy),
        .hazard(a_haz), .stall_cycles(a_stall), .flush_count(a_flush)
    );

    pipeline_ctrl #(.MEM_WAIT(1), .FWD_EN(1'b0)) u_b (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .exe_br_taken(exe_br_taken),
        .freeze_pc(b_fpc), .freeze_ifid(b_fifid), .flush_ifid(b_flifid),
        .flush_idex(b_flidex), .freeze_all(b_fall), .mem_ready(b_rdy),
        .hazard(b_haz), .stall_cycles(b_stall), .flush_count(b_flush)
    );

    wire [6:0] ctl_a = {a_fpc, a_fifid, a_flifid, a_flidex, a_fall, a_rdy, a_haz};
    wire [6:0] ctl_b = {b_fpc, b_fifid, b_flifid, b_flidex, b_fall, b_rdy, b_haz};

    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_STALL  = 7'b1101001;
    localparam logic [6:0] C_FREEZE = 7'b1100100;
    localparam logic [6:0] C_READY  = 7'b0000010;
    localparam logic [6:0] C_BRHAZ  = 7'b0011001;
    localparam logic [6:0] C_BRRDY  = 7'b0011010;
    localparam logic [6:0] C_NOHAZ  = 7'b0000000;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        id_src1 = '0; id_src2 = '0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
        exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = '0; mem_wb_en = 1'b0; mem_req = 1'b0; exe_br_taken = 1'b0;
    endtask

    task automatic load_use(input logic is_load);
        exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = is_load;
        id_src1 = 4'd3; id_use_src1 = 1'b1;
    endtask

    // Inputs change on the falling edge; checks follow 1 time unit later,
    // well before the next rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clr_inputs();
        mem_req = 1'b1; exe_br_taken = 1'b1;
        load_use(1'b1);
        next_cycle(); #1;
        chk("rst_ctl_a", 16'(ctl_a), 16'(C_IDLE));
        chk("rst_ctl_b", 16'(ctl_b), 16'(C_IDLE));
        chk("rst_stall_a", a_stall, 16'd0);
        chk("rst_flush_b", b_flush, 16'd0);

        next_cycle();
        rst = 1'b0;
        clr_inputs();

        // Load-use hazard: both instances stall (B matches any EXE writer).
        next_cycle(); load_use(1'b1); #1;
        chk("lu_ctl_a", 16'(ctl_a), 16'(C_STALL));
        chk("lu_ctl_b", 16'(ctl_b), 16'(C_STALL));
        chk("lu_stall_a_pre", a_stall, 16'd0);
        next_cycle(); clr_inputs(); #1;
        chk("lu_stall_a_post", a_stall, 16'd1);
        chk("lu_ctl_a_after", 16'(ctl_a), 16'(C_IDLE));

        // Non-load producer: forwarding hides it in A, B still stalls.
        next_cycle(); load_use(1'b0); #1;
        chk("alu_ctl_a", 16'(ctl_a), 16'(C_NOHAZ));
        chk("alu_ctl_b", 16'(ctl_b), 16'(C_STALL));
        next_cycle(); clr_inputs(); #1;
        chk("alu_stall_a", a_stall, 16'd1);
        chk("alu_stall_b", b_stall, 16'd2);

        // MEM-stage producer on src2.
        next_cycle();
        mem_dest = 4'd5; mem_wb_en = 1'b1; id_src2 = 4'd5; id_use_src2 = 1'b1; #1;
        chk("nf_haz_b", 16'(b_haz), 16'd1);
        chk("nf_ctl_b", 16'(ctl_b), 16'(C_STALL));
        chk("nf_ctl_a", 16'(ctl_a), 16'(C_NOHAZ));
        next_cycle(); id_use_src2 = 1'b0; #1;
        chk("nf_unused_haz_b", 16'(b_haz), 16'd0);
        chk("nf_stall_b", b_stall, 16'd3);

        // Taken branch overrides an active hazard.
        next_cycle(); clr_inputs(); load_use(1'b1); exe_br_taken = 1'b1; #1;
        chk("br_ctl_a", 16'(ctl_a), 16'(C_BRHAZ));
        chk("br_ctl_b", 16'(ctl_b), 16'(C_BRHAZ));
        next_cycle(); clr_inputs(); #1;
        chk("br_flush_a", a_flush, 16'd1);
        chk("br_flush_b", b_flush, 16'd1);
        chk("br_stall_a", a_stall, 16'd1);
        chk("br_stall_b", b_stall, 16'd3);

        // Memory freeze, mem_req held; branch raised during the freeze.
        next_cycle(); mem_req = 1'b1; #1;          // cycle 0
        chk("mf0_a", 16'(ctl_a), 16'(C_FREEZE));
        chk("mf0_b", 16'(ctl_b), 16'(C_FREEZE));
        next_cycle(); #1;                           // cycle 1
        chk("mf1_a", 16'(ctl_a), 16'(C_FREEZE));
        chk("mf1_b", 16'(ctl_b), 16'(C_READY));
        next_cycle(); exe_br_taken = 1'b1; #1;      // cycle 2
        chk("mf2_a", 16'(ctl_a), 16'(C_FREEZE));
        chk("mf2_b_b2b", 16'(ctl_b), 16'(C_FREEZE));
        next_cycle(); #1;                           // cycle 3
        chk("mf3_a", 16'(ctl_a), 16'(C_FREEZE));
        chk("mf3_b", 16'(ctl_b), 16'(C_BRRDY));
        next_cycle(); #1;                           // cycle 4
        chk("mf4_a", 16'(ctl_a), 16'(C_BRRDY));
        chk("mf4_b", 16'(ctl_b), 16'(C_FREEZE));
        next_cycle(); mem_req = 1'b0; exe_br_taken = 1'b0; #1;   // cycle 5
        chk("mf5_a", 16'(ctl_a), 16'(C_IDLE));
        chk("mf5_b", 16'(ctl_b), 16'(C_READY));
        next_cycle(); #1;                           // cycle 6
        chk("mf6_a", 16'(ctl_a), 16'(C_IDLE));
        chk("mf6_b", 16'(ctl_b), 16'(C_IDLE));
        chk("mf_flush_a", a_flush, 16'd2);
        chk("mf_flush_b", b_flush, 16'd2);

        // Reset in the middle of A's WAIT.
        next_cycle(); mem_req = 1'b1; #1;
        chk("rw0_a", 16'(ctl_a), 16'(C_FREEZE));
        next_cycle(); #1;
        chk("rw1_a", 16'(ctl_a), 16'(C_FREEZE));
        next_cycle(); rst = 1'b1; #1;
        chk("rw_rst_ctl_a", 16'(ctl_a), 16'(C_IDLE));
        chk("rw_rst_ctl_b", 16'(ctl_b), 16'(C_IDLE));
        chk("rw_rst_stall_a", a_stall, 16'd0);
        chk("rw_rst_flush_a", a_flush, 16'd0);
        next_cycle(); rst = 1'b0; mem_req = 1'b0; #1;
        chk("rw_after_a", 16'(ctl_a), 16'(C_IDLE));
        chk("rw_after_b", 16'(ctl_b), 16'(C_IDLE));

        // Fresh access after reset: full MEM_WAIT=4 sequence on A.
        next_cycle(); mem_req = 1'b1; #1;
        chk("fa0_a", 16'(ctl_a), 16'(C_FREEZE));
        next_cycle(); mem_req = 1'b0; #1;
        chk("fa1_a", 16'(ctl_a), 16'(C_FREEZE));
        chk("fa1_b", 16'(ctl_b), 16'(C_READY));
        next_cycle(); #1;
        chk("fa2_a", 16'(ctl_a), 16'(C_FREEZE));
        chk("fa2_b", 16'(ctl_b), 16'(C_IDLE));
        next_cycle(); #1;
        chk("fa3_a", 16'(ctl_a), 16'(C_FREEZE));
        next_cycle(); #1;
        chk("fa4_a", 16'(ctl_a), 16'(C_READY));
        next_cycle(); #1;
        chk("fa5_a", 16'(ctl_a), 16'(C_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
